// File: rtl/cyclic_code_pkg.sv
// rtl/cyclic_code_pkg.sv - shared (7,4) cyclic Hamming code constants, FSM states and helpers
package cyclic_code_pkg;

    localparam int N = 7;
    localparam int K = 4;
    localparam int R = 3;

    // g(x) = x^3 + x + 1
    localparam logic [R:0] GEN = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_CORRECT = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    // Syndrome equals x^pos mod g(x); 000 has no position and must be gated by the caller.
    function automatic logic [2:0] syn_to_pos(input logic [R-1:0] syn);
        logic [2:0] pos;
        pos = 3'd0;
        case (syn)
            3'b001:  pos = 3'd0;
            3'b010:  pos = 3'd1;
            3'b100:  pos = 3'd2;
            3'b011:  pos = 3'd3;
            3'b110:  pos = 3'd4;
            3'b111:  pos = 3'd5;
            3'b101:  pos = 3'd6;
            default: pos = 3'd0;
        endcase
        return pos;
    endfunction

    // Parity bits of a systematic codeword: data * x^R mod g(x).
    function automatic logic [R-1:0] calc_remainder(input logic [K-1:0] data);
        logic [R-1:0] rem;
        logic         fb;
        rem = '0;
        for (int i = K - 1; i >= 0; i--) begin
            fb  = data[i] ^ rem[R-1];
            rem = {rem[R-2:0], 1'b0} ^ (fb ? GEN[R-1:0] : '0);
        end
        return rem;
    endfunction

endpackage

// File: rtl/cyclic_syndrome_lfsr.sv
// rtl/cyclic_syndrome_lfsr.sv - serial divide-by-g(x) register producing the received-word syndrome
module cyclic_syndrome_lfsr
    import cyclic_code_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [R-1:0] syndrome
);

    // Each step computes (r(x) * x + din) mod g(x).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syndrome <= '0;
        end else if (clr) begin
            syndrome <= '0;
        end else if (en) begin
            syndrome <= {syndrome[R-2:0], din} ^ (syndrome[R-1] ? GEN[R-1:0] : '0);
        end
    end

endmodule

// File: rtl/cyclic_decoder.sv
// rtl/cyclic_decoder.sv - serial (7,4) cyclic Hamming decoder; CYCLIC_DEC_CORRECT_EN enables single-bit correction
module cyclic_decoder
    import cyclic_code_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic din_valid,
    input  logic datain,
    output logic dataout,
    output logic dout_valid,
    output logic err_detected,
    output logic err_corrected,
    output logic busy
);

    localparam logic [2:0] LAST_BIT = 3'(N - 1);
    localparam logic [2:0] OUT_DONE = 3'(K);

    state_t         state;
    logic [N-1:0]   cw_buf;
    logic [2:0]     bit_cnt;
    logic [2:0]     out_cnt;
    logic [R-1:0]   syndrome;
    logic           syn_clr;
    logic           syn_en;

    assign syn_clr = (state == ST_IDLE) && start;
    assign syn_en  = (state == ST_RECV) && din_valid;
    assign busy    = (state != ST_IDLE);

    cyclic_syndrome_lfsr u_syndrome (
        .clk      (clk),
        .rst      (rst),
        .clr      (syn_clr),
        .en       (syn_en),
        .din      (datain),
        .syndrome (syndrome)
    );

`ifndef CYCLIC_DEC_CORRECT_EN
    assign err_corrected = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cw_buf       <= '0;
            bit_cnt      <= '0;
            out_cnt      <= '0;
            dataout      <= 1'b0;
            dout_valid   <= 1'b0;
            err_detected <= 1'b0;
`ifdef CYCLIC_DEC_CORRECT_EN
            err_corrected <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    dataout    <= 1'b0;
                    dout_valid <= 1'b0;
                    if (start) begin
                        state        <= ST_RECV;
                        cw_buf       <= '0;
                        bit_cnt      <= '0;
                        out_cnt      <= '0;
                        err_detected <= 1'b0;
`ifdef CYCLIC_DEC_CORRECT_EN
                        err_corrected <= 1'b0;
`endif
                    end
                end
                ST_RECV: begin
                    if (din_valid) begin
                        cw_buf <= {cw_buf[N-2:0], datain};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_CORRECT;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_CORRECT: begin
                    err_detected <= |syndrome;
`ifdef CYCLIC_DEC_CORRECT_EN
                    err_corrected <= |syndrome;
                    if (|syndrome) begin
                        cw_buf <= cw_buf ^ (7'b1 << syn_to_pos(syndrome));
                    end
`endif
                    out_cnt <= '0;
                    state   <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    // Data bits sit in the top K positions; shift them out MSB first.
                    if (out_cnt == OUT_DONE) begin
                        dataout    <= 1'b0;
                        dout_valid <= 1'b0;
                        out_cnt    <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        dataout    <= cw_buf[N-1];
                        dout_valid <= 1'b1;
                        cw_buf     <= {cw_buf[N-2:0], 1'b0};
                        out_cnt    <= out_cnt + 3'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dataout    <= 1'b0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cyclic_decoder.md
CYCLIC_DECODER -- requirements
Module: cyclic_decoder

Interface
REQ-001 SHALL use reset rst, asynchronous, active-low; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin receiving a codeword; honoured only in IDLE.
REQ-005 din_valid  input  1  qualifies datain during RECV; low stalls reception.
REQ-006 datain  input  1  serial received bit; highest-order coefficient first (x^6 .. x^0 = m3 m2 m1 m0 r2 r1 r0).
REQ-007 dataout  output  1  serial decoded bit, m3 first; registered.
REQ-008 dout_valid  output  1  high while dataout carries a decoded bit.
REQ-009 err_detected  output  1  nonzero syndrome on the last codeword; held until next accepted start.
REQ-010 err_corrected  output  1  a bit flip was applied to the last codeword; held until next accepted start.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL decode the systematic (7,4) cyclic Hamming code with generator g(x)=x^3+x+1.
REQ-013 SHALL implement FSM states IDLE, RECV, CORRECT, OUTPUT; IDLE->RECV on start; RECV->CORRECT when the 7th bit is accepted; CORRECT->OUTPUT after exactly one cycle; OUTPUT->IDLE after the last output bit.
REQ-014 SHALL, on each RECV edge with din_valid=1, shift datain into a 7-bit buffer and update the syndrome {s2,s1,s0}: s2<=s1, s1<=s0^s2, s0<=datain^s2; bit counter 0..6 increments.
REQ-015 SHALL clear syndrome, buffer, bit counter, err_detected and err_corrected on the edge that accepts start.
REQ-016 SHALL ignore din_valid/datain in the cycle start is accepted; the first codeword bit is sampled on the following edge at the earliest.
REQ-017 SHALL ignore start in every state except IDLE.
REQ-018 SHALL, in CORRECT, map syndrome to error position: 001->x^0, 010->x^1, 100->x^2, 011->x^3, 110->x^4, 111->x^5, 101->x^6; 000->no flip; invert that buffer bit and set err_detected (syndrome!=0) and err_corrected.
REQ-019 SHALL, in OUTPUT, drive m3, m2, m1, m0 on consecutive cycles with dout_valid=1; dout_valid rises on the second edge after the 7th-bit edge and lasts exactly 4 cycles (output length per REQ-025).
REQ-020 SHALL hold dataout=0 and dout_valid=0 whenever not in OUTPUT.
REQ-021 SHALL, with din_valid gaps in RECV, hold all state unchanged; no timeout.

Reset
REQ-022 SHALL on rst=0, at any time including mid-codeword, force IDLE and zero buffer, syndrome, counters, dataout, dout_valid, err_detected, err_corrected, busy; the partial codeword is discarded.
REQ-023 SHALL resume normal operation on the first edge after rst deasserts; start may be accepted on that edge.

Configuration
REQ-024 SHALL use macro CYCLIC_DEC_CORRECT_EN: defined -> REQ-018 flip applied and err_corrected=err_detected; undefined -> detect-only, buffer never modified, err_corrected tied 0.
REQ-025 SHALL output 4 data bits per codeword in both configurations; parity bits are never output.

Structure
REQ-026 SHALL place in shared package cyclic_code_pkg: N=7, K=4, R=3, generator constant, FSM state enum, syndrome-to-position function.
REQ-027 SHALL instantiate one sub-module cyclic_syndrome_lfsr (3-bit divide-by-g(x) register with clear, enable, serial input); the encoder-side remainder logic shares this package.

Verification
REQ-028 start; bits 1000101, din_valid continuous -> dataout 1,0,0,0; err_detected=0, err_corrected=0.
REQ-029 bits 0000101 (x^6 flipped) -> syndrome 101; dataout 1,0,0,0; err_detected=1, err_corrected=1 (0 if macro undefined, dataout 0,0,0,0).
REQ-030 bits 1011001 (x^0 flipped, data 1011) with din_valid low 3 cycles after bit 3 -> dataout 1,0,1,1; dout_valid exactly 4 cycles, 2 edges after last accepted bit.
REQ-031 bits 0111000 (double error on 1011000) -> syndrome 010, miscorrection to data 0111, err_detected=1; start pulses during RECV/OUTPUT ignored.
REQ-032 rst low after 4 bits, then start with bits 0000000 -> all outputs 0 during reset; dataout 0,0,0,0, err_detected=0.
